// File: rtl/writeback_arbiter.sv
// Two-port fair writeback arbiter driving the register file write port, plus its write-port decoder.
// One-cycle accept-to-write latency; ready is combinational from valids/last_grant, output never stalls.

// Write-port decoder: one-hot of index when enable is high, else zero.
// Purely combinational; no backpressure.
module wb_decoder #(
   parameter int REG_W = 5
) (
   input  logic                    enable,
   input  logic [REG_W-1:0]        index,
   output logic [(1<<REG_W)-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (enable) begin
         onehot[index] = 1'b1;
      end
   end

endmodule

// Round-robin arbiter between writeback ports A and B, registered write onto the register file.
// Latency 1 cycle accept-to-write; grants at most one port per cycle, output stage never stalls.
module writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    ctrl_reset_n,
   input  logic                    a_valid,
   input  logic [REG_W-1:0]        a_reg,
   input  logic [DATA_W-1:0]       a_data,
   output logic                    a_ready,
   input  logic                    b_valid,
   input  logic [REG_W-1:0]        b_reg,
   input  logic [DATA_W-1:0]       b_data,
   output logic                    b_ready,
   output logic                    ctrl_writeEnable,
   output logic [REG_W-1:0]        ctrl_writeReg,
   output logic [DATA_W-1:0]       data_writeReg,
   output logic [(1<<REG_W)-1:0]   wb_onehot,
   output logic [CNT_W-1:0]        conflict_count
);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef struct packed {
      logic [REG_W-1:0]  idx;
      logic [DATA_W-1:0] dat;
   } wr_t;

   port_e last_grant;
   wr_t   win_wr;
   logic  xfer;
   logic  both_vld;

   // Ready depends only on the valids and last_grant, never on reg/data.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (ctrl_reset_n) begin
         if (a_valid && (!b_valid || last_grant == PORT_B)) begin
            a_ready = 1'b1;
         end else if (b_valid) begin
            b_ready = 1'b1;
         end
      end
   end

   assign xfer     = a_ready | b_ready;
   assign both_vld = a_valid & b_valid;

   always_comb begin
      win_wr = '{idx: b_reg, dat: b_data};
      if (a_ready) begin
         win_wr = '{idx: a_reg, dat: a_data};
      end
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         last_grant       <= PORT_B;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         conflict_count   <= '0;
      end else begin
         if (xfer) begin
            last_grant       <= a_ready ? PORT_A : PORT_B;
            // Register 0 is hardwired: the transfer is consumed but never written.
            ctrl_writeEnable <= (win_wr.idx != '0);
            ctrl_writeReg    <= win_wr.idx;
            data_writeReg    <= win_wr.dat;
         end else begin
            ctrl_writeEnable <= 1'b0;
         end
         if (both_vld && (conflict_count != '1)) begin
            conflict_count <= conflict_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   wb_decoder #(
      .REG_W (REG_W)
   ) u_wb_decoder (
      .enable (ctrl_writeEnable),
      .index  (ctrl_writeReg),
      .onehot (wb_onehot)
   );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_writeback_arbiter;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                  clock;
   logic                  ctrl_reset_n;
   logic                  a_valid, b_valid;
   logic [REG_W-1:0]      a_reg, b_reg;
   logic [DATA_W-1:0]     a_data, b_data;
   logic                  a_ready, b_ready;
   logic                  ctrl_writeEnable;
   logic [REG_W-1:0]      ctrl_writeReg;
   logic [DATA_W-1:0]     data_writeReg;
   logic [31:0]           wb_onehot;
   logic [CNT_W-1:0]      conflict_count;

   writeback_arbiter #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clock            (clock),
      .ctrl_reset_n     (ctrl_reset_n),
      .a_valid          (a_valid),
      .a_reg            (a_reg),
      .a_data           (a_data),
      .a_ready          (a_ready),
      .b_valid          (b_valid),
      .b_reg            (b_reg),
      .b_data           (b_data),
      .b_ready          (b_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .wb_onehot        (wb_onehot),
      .conflict_count   (conflict_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          en;
      logic [4:0]  r;
      logic [31:0] d;
      logic [31:0] oh;
      int          cnt;
   } rec_t;

   rec_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference state: what the register file should see, who won last, conflict tally.
   bit          m_en   = 0;
   logic [4:0]  m_reg  = '0;
   logic [31:0] m_data = '0;
   bit          m_last_b = 1;
   int          m_cnt  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: each cycle, compare visible outputs with the record predicted at the previous edge.
   always @(posedge clock) begin : monitor
      rec_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_we", ctrl_writeEnable, e.en);
         chk("sb_reg", ctrl_writeReg, e.r);
         chk("sb_data", data_writeReg, e.d);
         chk("sb_onehot", wb_onehot, e.oh);
         chk("sb_count", conflict_count, e.cnt);
      end
   end

   // One clock of stimulus: check grants, advance the model, push expected output, retire accepted requests.
   task automatic step();
      bit   ga, gb;
      rec_t r;
      @(negedge clock);
      ga = ctrl_reset_n && a_valid && (!b_valid || m_last_b);
      gb = ctrl_reset_n && b_valid && !ga;
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      if (!ctrl_reset_n) begin
         m_en = 0; m_reg = '0; m_data = '0; m_cnt = 0; m_last_b = 1;
      end else begin
         if (a_valid && b_valid && m_cnt < CMAX) m_cnt++;
         if (ga) begin
            m_reg = a_reg; m_data = a_data; m_en = (a_reg != 0); m_last_b = 0;
         end else if (gb) begin
            m_reg = b_reg; m_data = b_data; m_en = (b_reg != 0); m_last_b = 1;
         end else begin
            m_en = 0;
         end
      end
      r.en = m_en; r.r = m_reg; r.d = m_data; r.cnt = m_cnt;
      r.oh = m_en ? (32'h1 << m_reg) : 32'h0;
      sb.push_back(r);
      @(posedge clock);
      #1;
      if (ga) a_valid = 1'b0;
      if (gb) b_valid = 1'b0;
   endtask

   task automatic req_a(input logic [4:0] r, input logic [31:0] d);
      a_valid = 1'b1; a_reg = r; a_data = d;
   endtask

   task automatic req_b(input logic [4:0] r, input logic [31:0] d);
      b_valid = 1'b1; b_reg = r; b_data = d;
   endtask

   initial begin
      ctrl_reset_n = 1'b0;
      a_valid = 1'b0; a_reg = '0; a_data = '0;
      b_valid = 1'b0; b_reg = '0; b_data = '0;

      // Post-reset idle, then a single A write to r5.
      step();
      step();
      #2;
      chk("rst_we", ctrl_writeEnable, 1'b0);
      chk("rst_onehot", wb_onehot, 32'h0);
      chk("rst_count", conflict_count, 4'd0);
      ctrl_reset_n = 1'b1;
      req_a(5'd5, 32'hDEADBEEF);
      step();
      #2;
      chk("first_we", ctrl_writeEnable, 1'b1);
      chk("first_reg", ctrl_writeReg, 5'd5);
      chk("first_data", data_writeReg, 32'hDEADBEEF);
      chk("first_onehot", wb_onehot, 32'h00000020);

      // Full contention from reset: A, B, A, B, A, B.
      ctrl_reset_n = 1'b0;
      step();
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (!a_valid) req_a(5'd1, 32'hA000 + i);
         if (!b_valid) req_b(5'd2, 32'hB000 + i);
         step();
         #2;
         chk("contend_reg", ctrl_writeReg, (i % 2 == 0) ? 5'd1 : 5'd2);
      end
      chk("contend_count", conflict_count, 4'd6);
      step();

      // Register 0 via B: accepted but not written; next conflict goes to A.
      req_b(5'd0, 32'h1234);
      step();
      #2;
      chk("r0_we", ctrl_writeEnable, 1'b0);
      chk("r0_onehot", wb_onehot, 32'h0);
      chk("r0_data", data_writeReg, 32'h1234);
      req_a(5'd3, 32'h33);
      req_b(5'd4, 32'h44);
      step();
      #2;
      chk("r0_next_winner", ctrl_writeReg, 5'd3);
      step();

      // Back-to-back singles on A.
      for (int i = 0; i < 3; i++) begin
         req_a(5'(31 - i), $urandom);
         step();
         #2;
         chk("b2b_onehot", wb_onehot, 32'h80000000 >> i);
      end

      // Reset the cycle after an accepted write; pending B waits for deassertion.
      req_a(5'd7, 32'h77);
      step();
      req_b(5'd9, 32'h99);
      ctrl_reset_n = 1'b0;
      step();
      #2;
      chk("midrst_we", ctrl_writeEnable, 1'b0);
      chk("midrst_reg", ctrl_writeReg, 5'd0);
      ctrl_reset_n = 1'b1;
      step();
      #2;
      chk("midrst_b_we", ctrl_writeEnable, 1'b1);
      chk("midrst_b_reg", ctrl_writeReg, 5'd9);

      // Counter saturation.
      ctrl_reset_n = 1'b0;
      step();
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!a_valid) req_a(5'($urandom_range(1, 31)), $urandom);
         if (!b_valid) req_b(5'($urandom_range(1, 31)), $urandom);
         step();
      end
      #2;
      chk("sat_count", conflict_count, 4'd15);
      step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         ctrl_reset_n = ($urandom_range(0, 59) != 0);
         if (!a_valid && $urandom_range(0, 2) != 0) req_a(5'($urandom_range(0, 31)), $urandom);
         if (!b_valid && $urandom_range(0, 2) != 0) req_b(5'($urandom_range(0, 31)), $urandom);
         step();
      end
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step();

      @(posedge clock);
      #3;
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the register file's single write port between two writeback requesters: port A (ALU/load path) and port B (multiply/divide unit). It arbitrates fairly with a valid/ready handshake and registers the winning write onto the `ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg` inputs of the register file. It also exposes a one-hot decode of the in-flight write for bypass and hazard logic. It sits between the execute/writeback stage and the register file.

## Interface

Parameters:
- `DATA_W`, 32: width of write data.
- `REG_W`, 5: width of register index; the register file has 2^REG_W entries.
- `CNT_W`, 16: width of the conflict counter.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `ctrl_reset_n`  in  1  reset, synchronous, active-low.
- `a_valid`  in  1  port A has a write pending.
- `a_reg`  in  REG_W  port A destination register.
- `a_data`  in  DATA_W  port A write data.
- `a_ready`  out  1  port A granted this cycle.
- `b_valid`, `b_reg`, `b_data`, `b_ready`: same as port A, for port B.
- `ctrl_writeEnable`  out  1  registered write enable to the register file.
- `ctrl_writeReg`  out  REG_W  registered destination index.
- `data_writeReg`  out  DATA_W  registered write data.
- `wb_onehot`  out  2^REG_W  one-hot decode of `ctrl_writeReg`, gated by `ctrl_writeEnable`; all zero when no write.
- `conflict_count`  out  CNT_W  saturating count of cycles with both ports valid.

## Operation

- **Handshake:** a transfer occurs on a port when valid and ready are both high at a rising edge.
  - Once a requester raises valid, it holds valid, reg and data stable until it is accepted.
  - The arbiter never withdraws ready within a cycle.
- **Grant:** at most one grant per cycle. `a_ready` and `b_ready` are combinational from the valids and `last_grant`.
  - Only one port valid: that port is granted.
  - Both ports valid: the port not named by `last_grant` is granted.
  - Neither valid: no grant.
- **`last_grant`:** a 1-bit flop that updates to the granted port on every transfer and holds otherwise.
- **Output stage:** one register stage that never stalls, because the register file write port accepts every cycle. On a transfer, it loads the granted port's reg/data and sets the enable. With no transfer, it clears the enable and holds reg/data.
- **Register 0:**
  - A transfer to register 0 is accepted (ready high, `last_grant` updates).
  - It produces `ctrl_writeEnable` = 0 in the following cycle.
  - `ctrl_writeReg` and `data_writeReg` still load the transferred values.
- **`wb_onehot`:** equals 1 shifted left by `ctrl_writeReg` when the enable is high, otherwise 0. It is produced by instantiating the existing write-port decoder, with `ctrl_writeEnable` as its enable.
- **`conflict_count`:** increments by 1 on each edge where both valids are high, and saturates at 2^CNT_W−1.
- **Reset** (`ctrl_reset_n` low at a rising edge):
  - `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg` and `conflict_count` are 0.
  - `last_grant` is set to B, so A wins the first conflict.
  - While `ctrl_reset_n` is low, `a_ready` and `b_ready` are forced to 0 and no transfer occurs.
  - An in-flight output write is dropped.

## Timing

- **Latency:** a transfer sampled at edge k drives `ctrl_writeEnable` high during the cycle between edges k and k+1. The register file commits at edge k+1. Latency is 1 cycle from accept to visible write, and 2 edges from accept to commit.
- **Throughput:** one write per cycle.
- **Fairness:** a continuously valid port waits at most 1 cycle under full contention.
- **Alternation:** with both ports continuously valid, grants alternate A, B, A, B… starting from A after reset.
- **Ready path:** `a_ready` and `b_ready` are combinational from the valids and `last_grant` only. There is no combinational path from the data or reg inputs to ready.
- **Decode path:** `wb_onehot` is combinational from the output registers only.
- **Reset timing:** reset asserted in the same cycle as a valid request takes priority. No grant is issued, and the request stays pending until after reset deasserts.

## Test plan

- **Post-reset idle:** reset, then idle. All outputs are 0 and `a_ready` = `b_ready` = 0 during reset. After reset, a single request `a_valid`=1, `a_reg`=5, `a_data`=0xDEADBEEF is granted that cycle. Next cycle: `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0xDEADBEEF, `wb_onehot`=0x00000020.
- **Full contention:** both ports valid for 6 cycles, A→reg 1, B→reg 2. The grant order is A, B, A, B, A, B; the output regs alternate 1, 2, …; `conflict_count`=6.
- **Register 0:** `b_valid` with `b_reg`=0, data 0x1234. `b_ready`=1, then next cycle `ctrl_writeEnable`=0 and `wb_onehot`=0. A following conflict is granted to A.
- **Back-to-back singles:** A valid on 3 consecutive cycles with regs 31, 30, 29. Writes appear on 3 consecutive cycles with `wb_onehot` = 0x80000000, 0x40000000, 0x20000000.
- **Reset mid-operation:** assert `ctrl_reset_n`=0 the cycle after an accepted write. The write enable is cleared, the write never commits, and a still-valid B request is granted only after deassertion.
- **Counter saturation:** with `CNT_W`=4, hold 20 conflict cycles. `conflict_count` stops at 15.
